// File: rtl/brownout_pkg.sv
// brownout_pkg: shared state encoding, widths and helpers for the brownout controller
package brownout_pkg;
    localparam int TRIP_W   = 3;
    localparam int SETTLE_W = 8;
    localparam int HOLD_W   = 16;
    localparam int CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MONITOR = 3'd2,
        ST_TRIP    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/brownout_filt.sv
// brownout_filt: synchronizer chain plus deglitch filter for one asynchronous comparator flag
module brownout_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int DEGLITCH    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic level
);
    localparam int CW = $clog2(DEGLITCH + 1);
    localparam logic [CW-1:0] LAST = CW'(DEGLITCH - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sample;

    assign sample = sync[SYNC_STAGES-1];

    // cnt tracks consecutive samples disagreeing with level; any agreeing sample restarts it
    always_ff @(posedge clk or posedge rst)
        if (rst || clr) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync  <= SYNC_STAGES'({sync, din});
            level <= (sample != level && cnt == LAST) ? sample : level;
            cnt   <= (sample == level || cnt == LAST) ? '0 : cnt + CW'(1);
        end
endmodule

// File: rtl/brownout_ctrl.sv
// brownout_ctrl: brownout/undervoltage detector sequencer with settle, trip and hold-off handling
module brownout_ctrl
    import brownout_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEGLITCH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_ena,
    input  logic [TRIP_W-1:0]   cfg_otrip,
    input  logic [TRIP_W-1:0]   cfg_vtrip,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic [HOLD_W-1:0]   cfg_holdoff,
    input  logic                clr_sticky,
    input  logic                brout_in,
    input  logic                vunder_in,
    output logic                ena,
    output logic [TRIP_W-1:0]   otrip,
    output logic [TRIP_W-1:0]   vtrip,
    output logic                sys_rst_req,
    output logic                irq,
    output logic                brout_sticky,
    output logic                vunder_sticky,
    output logic [CNT_W-1:0]    event_cnt,
    output logic [2:0]          state
);
    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   timer_q, timer_d;
    logic [TRIP_W-1:0]   otrip_d, vtrip_d;
    logic [CNT_W-1:0]    event_cnt_d;
    logic                ena_d, sys_rst_req_d, irq_d, brout_sticky_d, vunder_sticky_d;
    logic                brout_f, vunder_f, vunder_q, vunder_rise, trim_diff;
    logic                brout_set, vunder_set;

    brownout_filt #(.SYNC_STAGES(SYNC_STAGES), .DEGLITCH(DEGLITCH)) u_brout_filt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!cfg_ena),
        .din   (brout_in),
        .level (brout_f)
    );

    brownout_filt #(.SYNC_STAGES(SYNC_STAGES), .DEGLITCH(DEGLITCH)) u_vunder_filt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!cfg_ena),
        .din   (vunder_in),
        .level (vunder_f)
    );

    assign vunder_rise = vunder_f & ~vunder_q;
    assign trim_diff   = (cfg_otrip != otrip) || (cfg_vtrip != vtrip);
    assign state       = state_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        otrip_d    = otrip;
        vtrip_d    = vtrip;
        brout_set  = 1'b0;
        vunder_set = 1'b0;
        if (!cfg_ena) begin
            state_d = ST_OFF;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_SETTLE;
                    otrip_d = cfg_otrip;
                    vtrip_d = cfg_vtrip;
                    timer_d = HOLD_W'(cfg_settle);
                end
                ST_SETTLE: begin
                    state_d = (timer_q == '0) ? ST_MONITOR : ST_SETTLE;
                    timer_d = (timer_q == '0) ? timer_q : timer_q - HOLD_W'(1);
                end
                ST_MONITOR: begin
                    vunder_set = vunder_rise;
                    // a trip outranks a trim change arriving in the same cycle
                    if (brout_f) begin
                        state_d   = ST_TRIP;
                        brout_set = 1'b1;
                    end else if (trim_diff) begin
                        state_d = ST_SETTLE;
                        otrip_d = cfg_otrip;
                        vtrip_d = cfg_vtrip;
                        timer_d = HOLD_W'(cfg_settle);
                    end
                end
                ST_TRIP: begin
                    vunder_set = vunder_rise;
                    if (!brout_f) begin
                        state_d = ST_HOLDOFF;
                        timer_d = cfg_holdoff;
                    end
                end
                ST_HOLDOFF: begin
                    vunder_set = vunder_rise;
                    if (brout_f)
                        state_d = ST_TRIP;
                    else if (timer_q == '0)
                        state_d = ST_MONITOR;
                    else
                        timer_d = timer_q - HOLD_W'(1);
                end
                default: state_d = ST_OFF;
            endcase
        end
        // outputs follow the next state so they change on the same edge as the state
        ena_d           = state_d != ST_OFF;
        sys_rst_req_d   = state_d == ST_TRIP || state_d == ST_HOLDOFF;
        irq_d           = brout_set | vunder_set;
        brout_sticky_d  = brout_set | (brout_sticky & ~clr_sticky);
        vunder_sticky_d = vunder_set | (vunder_sticky & ~clr_sticky);
        event_cnt_d     = brout_set ? sat_inc(event_cnt) : clr_sticky ? '0 : event_cnt;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q       <= ST_OFF;
            timer_q       <= '0;
            ena           <= 1'b0;
            otrip         <= '0;
            vtrip         <= '0;
            sys_rst_req   <= 1'b0;
            irq           <= 1'b0;
            brout_sticky  <= 1'b0;
            vunder_sticky <= 1'b0;
            event_cnt     <= '0;
            vunder_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ena           <= ena_d;
            otrip         <= otrip_d;
            vtrip         <= vtrip_d;
            sys_rst_req   <= sys_rst_req_d;
            irq           <= irq_d;
            brout_sticky  <= brout_sticky_d;
            vunder_sticky <= vunder_sticky_d;
            event_cnt     <= event_cnt_d;
            vunder_q      <= vunder_f;
        end
endmodule
